// File: rtl/pipe_buf_stage_pkg.sv
// Shared types for the pipe_buf_stage two-entry skid buffer: occupancy state
// encoding and the per-cycle register-load decision.
package pipe_buf_stage_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } pipe_buf_state_e;

    localparam int unsigned OCC_W = 2;

    typedef struct packed {
        logic load_main;
        logic load_skid;
        logic skid_to_main;
    } pipe_buf_ld_t;

    function automatic logic [OCC_W-1:0] occupancy(input pipe_buf_state_e s);
        case (s)
            ONE:     occupancy = 2'd1;
            FULL:    occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_buf_stage_satcnt.sv
// pipe_buf_satcnt: W-bit counter that adds a 2-bit increment each cycle and
// sticks at all-ones instead of wrapping.
module pipe_buf_satcnt #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [1:0]   add_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [W+1:0] sum;

    always_comb begin
        sum   = {2'b00, cnt_q} + {{W{1'b0}}, add_i};
        cnt_d = cnt_q;
        if (sum > {2'b00, {W{1'b1}}}) begin
            cnt_d = {W{1'b1}};
        end else begin
            cnt_d = sum[W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_buf_stage.sv
// Two-entry skid buffer between pipeline stages with flush and optional
// statistics counters (enabled by defining PIPE_BUF_STATS_EN).
module pipe_buf_stage
    import pipe_buf_stage_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    input  logic             flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
    } stage_reg_t;

    pipe_buf_state_e state_q;
    pipe_buf_state_e state_d;
    logic            init_q;
    stage_reg_t      main_q;
    stage_reg_t      main_d;
    stage_reg_t      skid_q;
    pipe_buf_ld_t    ld;
    logic            in_fire;
    logic            out_fire;

    // Handshake outputs come only from flops; init_q holds in_ready low
    // until the first edge after reset is released.
    assign out_valid = (state_q != EMPTY);
    assign in_ready  = init_q & (state_q != FULL);
    assign out_data  = main_q.data;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        ld      = '0;
        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    ld.load_main = 1'b1;
                    state_d      = ONE;
                end
            end
            ONE: begin
                case ({in_fire, out_fire})
                    2'b10: begin
                        ld.load_skid = 1'b1;
                        state_d      = FULL;
                    end
                    2'b01: state_d = EMPTY;
                    2'b11: ld.load_main = 1'b1;
                    default: ;
                endcase
            end
            FULL: begin
                if (out_fire) begin
                    ld.skid_to_main = 1'b1;
                    state_d         = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        // A flush wins over everything; payload registers keep their contents.
        if (flush) begin
            state_d = EMPTY;
            ld      = '0;
        end
    end

    always_comb begin
        main_d = main_q;
        if (ld.load_main) begin
            main_d.data = in_data;
        end else if (ld.skid_to_main) begin
            main_d = skid_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EMPTY;
            init_q  <= 1'b0;
            main_q  <= '0;
        end else begin
            state_q <= state_d;
            init_q  <= 1'b1;
            main_q  <= main_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ld.load_skid) begin
            skid_q.data <= in_data;
        end
    end

`ifdef PIPE_BUF_STATS_EN
    logic [1:0] stall_add;
    logic [1:0] drop_add;

    // Entries lost to a flush: held ones plus a same-cycle accept, minus a
    // same-cycle delivery (out_fire implies at least one entry is held).
    assign stall_add = {1'b0, out_valid & ~out_ready};
    assign drop_add  = flush ? (occupancy(state_q) + {1'b0, in_fire} - {1'b0, out_fire})
                             : 2'd0;

    pipe_buf_satcnt #(.W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .add_i   (stall_add),
        .cnt_o   (stall_cnt)
    );

    pipe_buf_satcnt #(.W(CNT_W)) u_drop_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .add_i   (drop_add),
        .cnt_o   (drop_cnt)
    );
`else
    assign stall_cnt = '0;
    assign drop_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_buf_stage.sv
// Bench for pipe_buf_stage: directed vector table, random traffic against a
// queue model, async reset mid-transfer and counter saturation at CNT_W=2.
module tb_pipe_buf_stage;

`ifdef PIPE_BUF_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic        flush;
    logic [15:0] stall_cnt;
    logic [15:0] drop_cnt;

    logic        iv2;
    logic [31:0] d2;
    logic        ir2;
    logic        ov2;
    logic [31:0] od2;
    logic        ordy2;
    logic [1:0]  stall2;
    logic [1:0]  drop2;

    pipe_buf_stage #(.WIDTH(32), .CNT_W(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .flush     (flush),
        .stall_cnt (stall_cnt),
        .drop_cnt  (drop_cnt)
    );

    pipe_buf_stage #(.WIDTH(32), .CNT_W(2)) dut2 (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (iv2),
        .in_data   (d2),
        .in_ready  (ir2),
        .out_valid (ov2),
        .out_data  (od2),
        .out_ready (ordy2),
        .flush     (1'b0),
        .stall_cnt (stall2),
        .drop_cnt  (drop2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mq[$];
    bit          m_init;
    logic [15:0] m_stall;
    logic [15:0] m_drop;

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        fl;
        logic        e_ov;
        logic [31:0] e_od;
        logic        e_ir;
    } vec_t;

    vec_t tbl[19];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at posedge+1: drive inputs, check at negedge, advance model on the edge.
    task automatic step(input logic iv, input logic [31:0] d, input logic ordy, input logic fl,
                        input bit use_tbl, input logic e_ov, input logic [31:0] e_od,
                        input logic e_ir, input string tag);
        bit m_ov;
        bit m_ir;
        bit inf;
        bit outf;
        logic [16:0] dsum;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        #4;
        m_ov = (mq.size() > 0);
        m_ir = m_init && (mq.size() < 2);
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(m_ov));
        chk({tag, ".in_ready"}, 64'(in_ready), 64'(m_ir));
        if (m_ov) chk({tag, ".out_data"}, 64'(out_data), 64'(mq[0]));
        chk({tag, ".stall_cnt"}, 64'(stall_cnt), STATS ? 64'(m_stall) : 64'd0);
        chk({tag, ".drop_cnt"}, 64'(drop_cnt), STATS ? 64'(m_drop) : 64'd0);
        if (use_tbl) begin
            chk({tag, ".tbl_out_valid"}, 64'(out_valid), 64'(e_ov));
            chk({tag, ".tbl_in_ready"}, 64'(in_ready), 64'(e_ir));
            if (e_ov) chk({tag, ".tbl_out_data"}, 64'(out_data), 64'(e_od));
        end
        @(posedge clk);
        inf  = iv && m_ir;
        outf = m_ov && ordy;
        if (m_ov && !ordy && m_stall != 16'hFFFF) m_stall++;
        if (fl) begin
            dsum = {1'b0, m_drop} + 17'(mq.size()) + 17'(inf) - 17'(outf);
            m_drop = (dsum > 17'h0FFFF) ? 16'hFFFF : dsum[15:0];
            mq.delete();
        end else begin
            if (outf) void'(mq.pop_front());
            if (inf) mq.push_back(d);
        end
        m_init = 1'b1;
        #1;
    endtask

    initial begin
        in_valid = 0; in_data = 0; out_ready = 0; flush = 0;
        iv2 = 0; d2 = 0; ordy2 = 0;
        m_init = 0; m_stall = 0; m_drop = 0;

        // stream, back-pressure to FULL, flush from FULL, flush with in+out fire
        tbl[0]  = '{1'b1, 32'h11, 1'b1, 1'b0, 1'b0, 32'h0,  1'b1};
        tbl[1]  = '{1'b1, 32'h22, 1'b1, 1'b0, 1'b1, 32'h11, 1'b1};
        tbl[2]  = '{1'b1, 32'h33, 1'b1, 1'b0, 1'b1, 32'h22, 1'b1};
        tbl[3]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'h33, 1'b1};
        tbl[4]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0,  1'b1};
        tbl[5]  = '{1'b1, 32'hA1, 1'b0, 1'b0, 1'b0, 32'h0,  1'b1};
        tbl[6]  = '{1'b1, 32'hA2, 1'b0, 1'b0, 1'b1, 32'hA1, 1'b1};
        tbl[7]  = '{1'b1, 32'hA3, 1'b0, 1'b0, 1'b1, 32'hA1, 1'b0};
        tbl[8]  = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 32'hA1, 1'b0};
        tbl[9]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'hA1, 1'b0};
        tbl[10] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'hA2, 1'b1};
        tbl[11] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0,  1'b1};
        tbl[12] = '{1'b1, 32'hB1, 1'b0, 1'b0, 1'b0, 32'h0,  1'b1};
        tbl[13] = '{1'b1, 32'hB2, 1'b0, 1'b0, 1'b1, 32'hB1, 1'b1};
        tbl[14] = '{1'b1, 32'hB3, 1'b0, 1'b1, 1'b1, 32'hB1, 1'b0};
        tbl[15] = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,  1'b1};
        tbl[16] = '{1'b1, 32'hC1, 1'b1, 1'b0, 1'b0, 32'h0,  1'b1};
        tbl[17] = '{1'b1, 32'hC2, 1'b1, 1'b1, 1'b1, 32'hC1, 1'b1};
        tbl[18] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0,  1'b1};

        reset_n = 1'b0;
        #12;
        chk("rst.in_ready", 64'(in_ready), 64'd0);
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.out_data", 64'(out_data), 64'd0);
        chk("rst.stall_cnt", 64'(stall_cnt), 64'd0);
        chk("rst.drop_cnt", 64'(drop_cnt), 64'd0);
        #1 reset_n = 1'b1;
        @(posedge clk);
        m_init = 1'b1;
        #1;
        chk("rst.first_edge_in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 19; i++) begin
            step(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl, 1'b1,
                 tbl[i].e_ov, tbl[i].e_od, tbl[i].e_ir, $sformatf("vec%0d", i));
        end
        chk("vec.drop_total", 64'(drop_cnt), STATS ? 64'd3 : 64'd0);
        chk("vec.stall_total", 64'(stall_cnt), STATS ? 64'd5 : 64'd0);

        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 15) == 0), 1'b0, 1'b0, 32'h0, 1'b0,
                 $sformatf("rnd%0d", i));
        end
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, "rnd_drain");

        // async reset while holding one entry
        step(1'b1, 32'h7, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, "pre_arst");
        in_valid = 1'b0;
        chk("pre_arst.out_valid", 64'(out_valid), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst.out_valid", 64'(out_valid), 64'd0);
        chk("arst.in_ready", 64'(in_ready), 64'd0);
        chk("arst.out_data", 64'(out_data), 64'd0);
        chk("arst.stall_cnt", 64'(stall_cnt), 64'd0);
        chk("arst.drop_cnt", 64'(drop_cnt), 64'd0);
        #2 reset_n = 1'b1;
        mq.delete();
        m_stall = 0;
        m_drop  = 0;
        m_init  = 0;
        @(posedge clk);
        m_init = 1'b1;
        #1;
        step(1'b1, 32'h5, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, "post_arst0");
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h5, 1'b1, "post_arst1");
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, "post_arst2");

        // CNT_W=2 instance: hold out_ready low well past saturation
        iv2 = 1'b1;
        d2  = 32'h3C;
        @(posedge clk);
        #1 iv2 = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("sat.out_valid", 64'(ov2), 64'd1);
        chk("sat.out_data", 64'(od2), 64'h3C);
        chk("sat.stall_cnt", 64'(stall2), STATS ? 64'd3 : 64'd0);
        chk("sat.drop_cnt", 64'(drop2), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_buf_stage.md
PIPE_BUF_STAGE -- requirements
Module: pipe_buf_stage

Interface
REQ-001 The parameter WIDTH SHALL default to 32 and set the payload bits carried per entry (one packed stage-register struct).
REQ-002 The parameter CNT_W SHALL default to 16 and set the width of each statistics counter.
REQ-003 The port clk SHALL be an input, 1 bit wide, and is the single clock.
REQ-004 The port reset_n SHALL be an input, 1 bit wide, and is the asynchronous active-low reset.
REQ-005 The port in_valid SHALL be an input, 1 bit wide, and flags that the upstream stage offers in_data.
REQ-006 The port in_data SHALL be an input, WIDTH bits wide, and carries the upstream payload.
REQ-007 The port in_ready SHALL be an output, 1 bit wide, and flags that the block accepts in_data this cycle.
REQ-008 The port out_valid SHALL be an output, 1 bit wide, and flags that out_data is valid.
REQ-009 The port out_data SHALL be an output, WIDTH bits wide, and carries the payload to the downstream stage.
REQ-010 The port out_ready SHALL be an input, 1 bit wide, and flags that the downstream stage consumes out_data.
REQ-011 The port flush SHALL be an input, 1 bit wide, and requests a synchronous discard of all held entries (branch/jump redirect).
REQ-012 The port stall_cnt SHALL be an output, CNT_W bits wide, and counts cycles of back-pressure.
REQ-013 The port drop_cnt SHALL be an output, CNT_W bits wide, and counts entries discarded by flush.

Function
REQ-014 The block SHALL be a two-entry skid buffer: a main register drives out_data and a skid register absorbs one beat while back-pressure propagates.
REQ-015 State SHALL be one of EMPTY, ONE or FULL; in_fire = in_valid & in_ready and out_fire = out_valid & out_ready.
REQ-016 out_valid SHALL be 1 exactly when the state is not EMPTY, and in_ready SHALL be 1 exactly when the state is not FULL; both are decoded only from registered state, with no combinational path from out_ready or in_valid.
REQ-017 In EMPTY, in_fire SHALL load main and move the state to ONE.
REQ-018 In ONE, in_fire without out_fire SHALL load skid and move the state to FULL.
REQ-019 In ONE, out_fire without in_fire SHALL move the state to EMPTY.
REQ-020 In ONE, in_fire together with out_fire SHALL load main with in_data and keep the state at ONE.
REQ-021 In FULL, out_fire SHALL copy skid into main and move the state to ONE; no input is accepted in FULL.
REQ-022 Latency SHALL be 1 cycle from in_fire to out_valid, and throughput SHALL be 1 beat per cycle while out_ready stays 1.
REQ-023 Ordering SHALL be strict FIFO, with no duplication and no loss except by flush.
REQ-024 flush SHALL take priority over every other event: the next state is EMPTY, any same-cycle in_fire is discarded, and an out_fire in the same cycle still counts as delivered.
REQ-025 Data registers SHALL NOT be cleared by flush; only the state changes.
REQ-026 While out_valid is 1 and out_ready is 0, out_data SHALL remain stable.

Reset
REQ-027 Asserting reset_n low SHALL asynchronously force state EMPTY, in_ready 0 while asserted, out_valid 0, out_data 0, stall_cnt 0 and drop_cnt 0.
REQ-028 On the first clk edge after reset_n is released, in_ready SHALL be 1.
REQ-029 A reset asserted mid-transfer SHALL drop held entries without counting them in drop_cnt.

Configuration
REQ-030 With the macro PIPE_BUF_STATS_EN defined, stall_cnt SHALL increment each cycle in which out_valid is 1 and out_ready is 0.
REQ-031 With PIPE_BUF_STATS_EN defined, drop_cnt SHALL add on each flush the number of held entries (0, 1 or 2) plus 1 if in_fire occurred in that cycle, minus 1 if out_fire occurred.
REQ-032 With PIPE_BUF_STATS_EN defined, both counters SHALL saturate at 2^CNT_W-1.
REQ-033 Without PIPE_BUF_STATS_EN, both counter ports SHALL remain present and tied to 0, and no counter flops SHALL be synthesised.

Structure
REQ-034 A shared package SHALL hold the state enum (EMPTY=2'b00, ONE=2'b01, FULL=2'b10) and the stage-register struct typedefs whose widths instantiate WIDTH.
REQ-035 One sub-module, pipe_buf_satcnt, SHALL implement a parametrised saturating counter and be instantiated twice under PIPE_BUF_STATS_EN.

Verification
REQ-036 With out_ready held at 1 and in_data 0x11, 0x22, 0x33 on back-to-back cycles, out_data SHALL be 0x11, 0x22, 0x33 on consecutive cycles, each 1 cycle after its input, and in_ready SHALL stay 1.
REQ-037 With out_ready held at 0 and 0xA1 then 0xA2 sent, the state SHALL reach FULL, in_ready SHALL drop to 0, stall_cnt SHALL increase by 1 per cycle, and after out_ready rises 0xA1 then 0xA2 SHALL emerge in order.
REQ-038 With the block FULL and flush pulsed while in_valid is 1 and out_ready is 0, the next cycle SHALL show state EMPTY and out_valid 0, and drop_cnt SHALL increase by 2.
REQ-039 With reset_n pulsed low for 3 ns asynchronously in state ONE, all outputs SHALL clear immediately, and after release the first input 0x5 SHALL appear 1 cycle later.
REQ-040 With CNT_W=2 and out_ready held at 0 for 6 cycles, stall_cnt SHALL saturate at 3, and SHALL read 0 when the macro is undefined.
